// File: rtl/io_pkg.sv
// Shared definitions for the buffered I/O port:
// register map and bit positions of STATUS and CTRL.
package io_pkg;

   typedef enum logic [1:0] {
      ADDR_DATA   = 2'd0,
      ADDR_STATUS = 2'd1,
      ADDR_CTRL   = 2'd2,
      ADDR_RSVD   = 2'd3
   } addr_e;

   localparam int ST_RX_AVAIL = 0;
   localparam int ST_RX_FULL  = 1;
   localparam int ST_TX_SPACE = 2;
   localparam int ST_TX_EMPTY = 3;
   localparam int ST_RD_UNF   = 4;
   localparam int ST_WR_OVF   = 5;

   localparam int CTRL_IRQ_EN   = 0;
   localparam int CTRL_FLUSH_RX = 1;
   localparam int CTRL_FLUSH_TX = 2;
   localparam int CTRL_CLR      = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush, head-of-queue output
// and occupancy count; used for both RX and TX.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] P_ONE = 1;
   localparam logic [AW:0]   C_ONE = 1;
   localparam logic [AW:0]   C_MAX = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == C_MAX);
   assign count = r_count;
   assign dout  = empty ? '0 : r_mem[r_rptr];

   // A full FIFO still accepts a push when a pop frees the slot
   assign w_pop  = pop & ~empty;
   assign w_push = push & (~full | w_pop);

   // Pointer and count update; flush discards everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + P_ONE;
         if (w_pop)
            r_rptr <= r_rptr + P_ONE;
         if (w_push && !w_pop)
            r_count <= r_count + C_ONE;
         else if (w_pop && !w_push)
            r_count <= r_count - C_ONE;
      end
   end

   // Storage; contents are only visible while count is non-zero
   always_ff @(posedge clk) begin
      if (w_push && !flush)
         r_mem[r_wptr] <= din;
   end

endmodule

// File: rtl/io_port_buffered.sv
// FIFO-buffered CPU I/O port: register window on the CPU side,
// valid/ready streams on the peripheral side, sticky errors and IRQ.
module io_port_buffered
   import io_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic             re,
   input  logic [1:0]       addr,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             irq
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] w_rx_dout;
   logic             w_rx_full;
   logic             w_rx_empty;
   logic [CW-1:0]    w_rx_count;
   logic             w_tx_full;
   logic             w_tx_empty;
   logic [CW-1:0]    w_tx_count;

   logic w_rd_data;
   logic w_wr_data;
   logic w_wr_ctrl;
   logic w_rx_push;
   logic w_rx_pop;
   logic w_tx_push;
   logic w_tx_pop;
   logic w_flush_rx;
   logic w_flush_tx;
   logic w_clr;
   logic w_unf_set;
   logic w_ovf_set;

   logic r_rd_unf;
   logic r_wr_ovf;
   logic r_irq_en;
   logic r_irq;

   logic [WIDTH-1:0] w_status;

   addr_e w_addr;
   assign w_addr = addr_e'(addr);

   assign w_rd_data = re & (w_addr == ADDR_DATA);
   assign w_wr_data = we & (w_addr == ADDR_DATA);
   assign w_wr_ctrl = we & (w_addr == ADDR_CTRL);

   assign w_rx_push = in_valid & ~w_rx_full;
   assign w_rx_pop  = w_rd_data & ~w_rx_empty;
   assign w_tx_push = w_wr_data;
   assign w_tx_pop  = out_ready & ~w_tx_empty;

   assign w_flush_rx = w_wr_ctrl & data_in[CTRL_FLUSH_RX];
   assign w_flush_tx = w_wr_ctrl & data_in[CTRL_FLUSH_TX];
   assign w_clr      = w_wr_ctrl & data_in[CTRL_CLR];

   assign w_unf_set = w_rd_data & w_rx_empty;
   assign w_ovf_set = w_wr_data & w_tx_full & ~w_tx_pop;

   assign in_ready  = ~w_rx_full;
   assign out_valid = ~w_tx_empty;
   assign irq       = r_irq;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (w_flush_rx),
      .push  (w_rx_push),
      .din   (in_data),
      .pop   (w_rx_pop),
      .dout  (w_rx_dout),
      .full  (w_rx_full),
      .empty (w_rx_empty),
      .count (w_rx_count)
   );

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (w_flush_tx),
      .push  (w_tx_push),
      .din   (data_in),
      .pop   (w_tx_pop),
      .dout  (out_data),
      .full  (w_tx_full),
      .empty (w_tx_empty),
      .count (w_tx_count)
   );

   // Sticky error flags; a clear in the same cycle beats a set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_unf <= 1'b0;
         r_wr_ovf <= 1'b0;
      end else if (w_clr) begin
         r_rd_unf <= 1'b0;
         r_wr_ovf <= 1'b0;
      end else begin
         if (w_unf_set)
            r_rd_unf <= 1'b1;
         if (w_ovf_set)
            r_wr_ovf <= 1'b1;
      end
   end

   // Interrupt enable held from CTRL writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_irq_en <= 1'b0;
      else if (w_wr_ctrl)
         r_irq_en <= data_in[CTRL_IRQ_EN];
   end

   // Registered RX-data-available interrupt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_irq <= 1'b0;
      else
         r_irq <= r_irq_en & ~w_rx_empty;
   end

   // STATUS word assembled from FIFO state and sticky flags
   always_comb begin
      w_status              = '0;
      w_status[ST_RX_AVAIL] = (w_rx_count != '0);
      w_status[ST_RX_FULL]  = w_rx_full;
      w_status[ST_TX_SPACE] = ~w_tx_full;
      w_status[ST_TX_EMPTY] = (w_tx_count == '0);
      w_status[ST_RD_UNF]   = r_rd_unf;
      w_status[ST_WR_OVF]   = r_wr_ovf;
   end

   // CPU read mux; idle bus reads as zero
   always_comb begin
      data_out = '0;
      if (re) begin
         unique case (w_addr)
            ADDR_DATA:   data_out = w_rx_dout;
            ADDR_STATUS: data_out = w_status;
            ADDR_CTRL:   data_out[CTRL_IRQ_EN] = r_irq_en;
            default:     data_out = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_port_buffered.sv
// Directed self-checking bench for io_port_buffered
// with a closing random stream through a CPU echo loop.
module tb_io_port_buffered;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       we = 1'b0;
   logic       re = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] data_in = 8'h00;
   logic [7:0] data_out;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       irq;

   int n_asrt = 0;
   int n_fail = 0;

   io_port_buffered #(.WIDTH(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .re        (re),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      we = 1'b1; addr = a; data_in = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      re = 1'b1; addr = a;
      #1 d = data_out;
      @(negedge clk);
      re = 1'b0;
   endtask

   task automatic status(output logic [7:0] d);
      re = 1'b1; addr = 2'd1;
      #1 d = data_out;
      re = 1'b0;
   endtask

   logic [7:0] v;
   logic [7:0] s;
   logic [7:0] vec [1000];
   int sent;
   int rcv;
   int cyc;

   initial begin
      // reset asserted mid-cycle
      #12 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
      chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      chk("rst_data_out", data_out, 8'h00);
      status(v);
      chk("rst_status", v, 8'h0C);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // TX path
      wr(2'd0, 8'h11);
      wr(2'd0, 8'h22);
      wr(2'd0, 8'h33);
      wr(2'd0, 8'h44);
      #1;
      chk("tx_head", out_data, 8'h11);
      chk("tx_valid", {7'd0, out_valid}, 8'h01);
      status(v);
      chk("tx_full_status", v, 8'h00);
      @(negedge clk);
      wr(2'd0, 8'h55);
      status(v);
      chk("tx_ovf_status", v, 8'h20);
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("tx_stream%0d", i), out_data, 8'h11 * 8'(i + 1));
         @(negedge clk);
      end
      #1;
      chk("tx_drained_valid", {7'd0, out_valid}, 8'h00);
      chk("tx_drained_data", out_data, 8'h00);
      out_ready = 1'b0;
      status(v);
      chk("tx_after_status", v, 8'h2C);
      @(negedge clk);
      wr(2'd2, 8'h08);
      status(v);
      chk("clr_status", v, 8'h0C);
      @(negedge clk);

      // RX path
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = 8'hA0 + 8'(i);
         #1;
         chk($sformatf("rx_ready%0d", i), {7'd0, in_ready},
             (i < 4) ? 8'h01 : 8'h00);
         @(negedge clk);
      end
      in_valid = 1'b0;
      status(v);
      chk("rx_full_status", v, 8'h0F);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rd(2'd0, v);
         chk($sformatf("rx_read%0d", i), v, 8'hA0 + 8'(i));
      end
      rd(2'd0, v);
      chk("rx_empty_read", v, 8'h00);
      status(v);
      chk("rx_unf_status", v, 8'h1C);
      @(negedge clk);
      wr(2'd2, 8'h08);

      // IRQ
      wr(2'd2, 8'h01);
      rd(2'd2, v);
      chk("ctrl_read", v, 8'h01);
      chk("irq_idle", {7'd0, irq}, 8'h00);
      in_valid = 1'b1;
      in_data = 8'h5A;
      @(negedge clk);
      in_valid = 1'b0;
      chk("irq_push_edge", {7'd0, irq}, 8'h00);
      @(negedge clk);
      chk("irq_set", {7'd0, irq}, 8'h01);
      rd(2'd0, v);
      chk("irq_data", v, 8'h5A);
      chk("irq_pop_edge", {7'd0, irq}, 8'h01);
      @(negedge clk);
      chk("irq_clear", {7'd0, irq}, 8'h00);
      wr(2'd2, 8'h00);

      // Corners: read+push on full RX, then flush with push
      rd(2'd0, v);
      wr(2'd0, 8'h77);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = 8'hB0 + 8'(i);
         @(negedge clk);
      end
      re = 1'b1;
      addr = 2'd0;
      in_data = 8'hB4;
      #1;
      chk("corner_head", data_out, 8'hB0);
      chk("corner_ready", {7'd0, in_ready}, 8'h00);
      @(negedge clk);
      re = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("corner_ready_after", {7'd0, in_ready}, 8'h01);
      status(v);
      chk("corner_status", v, 8'h15);
      @(negedge clk);
      rd(2'd0, v);
      chk("corner_next", v, 8'hB1);
      in_valid = 1'b1;
      in_data = 8'hC0;
      wr(2'd2, 8'h0E);
      in_valid = 1'b0;
      status(v);
      chk("flush_status", v, 8'h0C);
      chk("flush_out_valid", {7'd0, out_valid}, 8'h00);
      @(negedge clk);

      // Random stream through the CPU echo loop
      for (int i = 0; i < 1000; i++)
         vec[i] = 8'($urandom);
      sent = 0;
      rcv = 0;
      cyc = 0;
      while (rcv < 1000 && cyc < 20000) begin
         in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_data = (sent < 1000) ? vec[sent] : 8'h00;
         out_ready = ($urandom_range(0, 3) != 0);
         re = 1'b1;
         addr = 2'd1;
         #1 s = data_out;
         if (s[0] && s[2] && ($urandom_range(0, 1) != 0)) begin
            addr = 2'd0;
            #1 data_in = data_out;
            we = 1'b1;
         end else begin
            re = 1'b0;
         end
         #1;
         if (in_valid && in_ready)
            sent++;
         if (out_valid && out_ready) begin
            chk("stream_word", out_data, vec[rcv]);
            rcv++;
         end
         @(negedge clk);
         we = 1'b0;
         re = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_asrt++;
      assert (rcv == 1000) else begin
         n_fail++;
         $error("FAIL stream_count: observed %0d expected 1000", rcv);
      end
      status(v);
      chk("stream_status", v, 8'h0C);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end

endmodule
